// File: rtl/agp32_mem_ctrl.sv
`timescale 1ns/1ps
// agp32 memory controller: each command becomes an optional data word access, then a fetch at PC. With zero-wait ack, ready returns 3 cycles after accept for a fetch and 5 for a data command.
// Commands that arrive while ready=0 are ignored; mem_req is held until mem_ack. Defining TIMEOUT_EN bounds each request to TIMEOUT cycles.
module agp32_mem_ctrl #(
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] RESET_INST = 32'd63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  command,
  input  logic [31:0] PC,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        ready,
  output logic [31:0] inst_rdata,
  output logic [31:0] data_rdata,
  output logic [1:0]  error,
  output logic        mem_start_ready,
  input  logic        mem_init_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_DATA, S_INST} state_t;

  state_t      r_state;
  logic        r_is_wr;
  logic [29:0] r_waddr;
  logic [29:0] r_pc;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic w_is_data;
  logic w_misaligned;
  logic w_to_hit;

  // Byte stores may carry the byte lane in addr[1:0], so a single-strobe write is legal.
  assign w_is_data    = (command == 3'd2) || (command == 3'd3);
  assign w_misaligned = (data_addr[1:0] != 2'b00) && !((command == 3'd3) && $onehot(data_wstrb));

`ifdef TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_to_cnt;

  // Counter is zero whenever mem_req is low, so every new request starts from 0.
  always_ff @(posedge clk) begin
    if (!rst_n || !mem_req) r_to_cnt <= '0;
    else                    r_to_cnt <= r_to_cnt + CW'(1);
  end

  assign w_to_hit = mem_req && !mem_ack && (r_to_cnt == CW'(TIMEOUT - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_INIT;
      r_is_wr         <= 1'b0;
      r_waddr         <= '0;
      r_pc            <= '0;
      r_wdata         <= '0;
      r_wstrb         <= '0;
      ready           <= 1'b0;
      mem_start_ready <= 1'b0;
      error           <= 2'b00;
      inst_rdata      <= RESET_INST;
      data_rdata      <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_wstrb       <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (mem_init_done) begin
            mem_start_ready <= 1'b1;
            ready           <= 1'b1;
            r_state         <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (command != 3'd0) begin
            ready   <= 1'b0;
            r_is_wr <= (command == 3'd3);
            r_waddr <= data_addr[31:2];
            r_pc    <= PC[31:2];
            r_wdata <= data_wdata;
            r_wstrb <= data_wstrb;
            if (w_is_data && !w_misaligned) begin
              r_state <= S_DATA;
            end else begin
              if (w_is_data) error[0] <= 1'b1;
              r_state <= S_INST;
            end
          end
        end
        S_DATA: begin
          // mem_req low here means the request has not been issued yet for this state.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= r_is_wr;
            mem_addr <= r_waddr;
            if (r_is_wr) begin
              mem_wdata <= r_wdata;
              mem_wstrb <= r_wstrb;
            end
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (!r_is_wr) data_rdata <= mem_rdata;
            r_state <= S_INST;
          end else if (w_to_hit) begin
            mem_req  <= 1'b0;
            error[1] <= 1'b1;
            r_state  <= S_INST;
          end
        end
        S_INST: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= r_pc;
          end else if (mem_ack) begin
            mem_req    <= 1'b0;
            inst_rdata <= mem_rdata;
            ready      <= 1'b1;
            r_state    <= S_IDLE;
          end else if (w_to_hit) begin
            mem_req    <= 1'b0;
            error[1]   <= 1'b1;
            inst_rdata <= RESET_INST;
            ready      <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_agp32_mem_ctrl.sv
`timescale 1ns/1ps
// Randomized bench for agp32_mem_ctrl against a word-level reference model and a wait-state memory stub.
module tb_agp32_mem_ctrl;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  command;
  logic [31:0] PC, data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        ready, mem_start_ready, mem_init_done;
  logic [31:0] inst_rdata, data_rdata;
  logic [1:0]  error;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  agp32_mem_ctrl #(.TIMEOUT(TO), .RESET_INST(32'd63)) dut (
    .clk(clk), .rst_n(rst_n), .command(command), .PC(PC), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .ready(ready),
    .inst_rdata(inst_rdata), .data_rdata(data_rdata), .error(error),
    .mem_start_ready(mem_start_ready), .mem_init_done(mem_init_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] a);
    if (a == 30'h40) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Backing memory owned by the stub; rmem is the model's independent view of it.
  logic [31:0] bmem [int unsigned];
  logic [31:0] rmem [int unsigned];

  function automatic logic [31:0] bm_rd(input logic [29:0] a);
    return bmem.exists({2'b00, a}) ? bmem[{2'b00, a}] : init_word(a);
  endfunction

  function automatic logic [31:0] rm_rd(input logic [29:0] a);
    return rmem.exists({2'b00, a}) ? rmem[{2'b00, a}] : init_word(a);
  endfunction

  int   mem_wait = 0;
  bit   no_ack = 1'b0;
  int   wcnt = 0;
  int   stab_err = 0;
  int   req_cycles = 0;
  txn_t obs_q[$];
  logic p_req = 1'b0;
  txn_t p_t;

  always @(negedge clk) begin
    txn_t t;
    t = '{mem_we, mem_addr, mem_wdata, mem_wstrb};
    if (mem_req && p_req && (t !== p_t)) stab_err++;
    p_req = mem_req;
    p_t   = t;
    if (mem_req) req_cycles++;
    if (mem_req && !no_ack) begin
      if (wcnt >= mem_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = bm_rd(mem_addr);
        if (mem_we) bmem[{2'b00, mem_addr}] = merge(bm_rd(mem_addr), mem_wdata, mem_wstrb);
        obs_q.push_back(t);
        wcnt = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      wcnt      = 0;
    end
  end

  logic [31:0] exp_inst = 32'd63;
  logic [31:0] exp_drd = 32'h0;
  logic [1:0]  exp_err = 2'b00;

  // Waits for ready while throwing garbage commands at the busy controller.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ready) break;
      command    = 3'($urandom_range(1, 7));
      PC         = $urandom;
      data_addr  = $urandom;
      data_wdata = $urandom;
      data_wstrb = 4'($urandom);
    end
    command = 3'd0;
  endtask

  task automatic run_cmd(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws, input int w);
    int   eff, lat, cyc, base;
    bit   mis;
    txn_t t;
    txn_t exp_q[$];
    eff = (c == 3'd2 || c == 3'd3) ? int'(c) : 1;
    mis = (eff != 1) && (a[1:0] != 2'b00) && !(eff == 3 && $countones(ws) == 1);
    if (mis) exp_err[0] = 1'b1;
    if (eff != 1 && !mis) begin
      t = '{eff == 3, a[31:2], wd, ws};
      exp_q.push_back(t);
      if (eff == 2) exp_drd = rm_rd(a[31:2]);
      else rmem[{2'b00, a[31:2]}] = merge(rm_rd(a[31:2]), wd, ws);
      lat = 5 + 2 * w;
    end else begin
      lat = 3 + w;
    end
    t = '{1'b0, pc[31:2], 32'h0, 4'h0};
    exp_q.push_back(t);
    exp_inst = rm_rd(pc[31:2]);

    base       = obs_q.size();
    mem_wait   = w;
    command    = c;
    PC         = pc;
    data_addr  = a;
    data_wdata = wd;
    data_wstrb = ws;
    wait_ready(cyc);

    check("latency", cyc, lat);
    check("txn_count", obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      check($sformatf("txn%0d_we", i), obs_q[base+i].we, exp_q[i].we);
      check($sformatf("txn%0d_addr", i), obs_q[base+i].addr, exp_q[i].addr);
      if (exp_q[i].we) begin
        check($sformatf("txn%0d_wdata", i), obs_q[base+i].wdata, exp_q[i].wdata);
        check($sformatf("txn%0d_wstrb", i), obs_q[base+i].wstrb, exp_q[i].wstrb);
      end
    end
    check("ready", ready, 1'b1);
    check("inst_rdata", inst_rdata, exp_inst);
    check("data_rdata", data_rdata, exp_drd);
    check("error", error, exp_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n = 1'b0; mem_init_done = 1'b0; command = 3'd0;
    PC = '0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_start", mem_start_ready, 1'b0);
    check("rst_error", error, 2'b00);
    check("rst_inst", inst_rdata, 32'd63);
    check("rst_drd", data_rdata, 32'h0);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 30'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wstrb", mem_wstrb, 4'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("init_ready", ready, 1'b0);
      check("init_start", mem_start_ready, 1'b0);
    end
    mem_init_done = 1'b1;
    @(negedge clk);
    check("up_ready", ready, 1'b1);
    check("up_start", mem_start_ready, 1'b1);
    check("up_inst", inst_rdata, 32'd63);

    run_cmd(3'd1, 32'h100, 32'h0, 32'h0, 4'h0, 2);
    run_cmd(3'd4, 32'h104, 32'h3, 32'h0, 4'h0, 0);
    run_cmd(3'd2, 32'h104, 32'h2000, 32'h0, 4'h0, 0);
    run_cmd(3'd3, 32'h108, 32'h2003, 32'hAB000000, 4'b1000, 0);
    run_cmd(3'd2, 32'h10C, 32'h2000, 32'h0, 4'h0, 1);
    run_cmd(3'd6, 32'hFFFFFFFC, 32'h2001, 32'h0, 4'h0, 0);
    run_cmd(3'd2, 32'h110, 32'h2002, 32'h0, 4'h0, 0);
    run_cmd(3'd3, 32'h114, 32'h2006, 32'h12345678, 4'b0011, 0);

    for (int k = 0; k < 40; k++) begin
      logic [2:0]  c;
      logic [31:0] a, pc;
      logic [3:0]  ws;
      c  = 3'($urandom_range(1, 7));
      if (c > 3'd4 && $urandom_range(0, 1) == 1) c = 3'($urandom_range(2, 3));
      a  = 32'h2000 + ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      ws = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      pc = ($urandom_range(0, 3) == 0) ? 32'h2000 + ($urandom_range(0, 7) << 2)
                                       : 32'h100 + ($urandom_range(0, 7) << 2);
      run_cmd(c, pc, a, $urandom, ws, $urandom_range(0, 3));
    end

`ifdef TIMEOUT_EN
    begin
      int rc0, base;
      no_ack = 1'b1;
      rc0 = req_cycles;
      base = obs_q.size();
      command = 3'd1; PC = 32'h180;
      wait_ready(cyc);
      exp_err[1] = 1'b1;
      check("to_latency", cyc, 2 + TO);
      check("to_req_cycles", req_cycles - rc0, TO);
      check("to_req_low", mem_req, 1'b0);
      check("to_error", error, exp_err);
      check("to_inst", inst_rdata, 32'd63);
      check("to_drd", data_rdata, exp_drd);
      check("to_no_txn", obs_q.size() - base, 0);
      no_ack = 1'b0;
    end
`endif

    no_ack = 1'b1;
    command = 3'd2; PC = 32'h100; data_addr = 32'h2010;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      command = 3'd0;
      if (mem_req) break;
    end
    check("abort_req_seen", mem_req, 1'b1);
    rst_n = 1'b0; mem_init_done = 1'b0;
    @(negedge clk);
    check("abort_req", mem_req, 1'b0);
    check("abort_ready", ready, 1'b0);
    check("abort_start", mem_start_ready, 1'b0);
    check("abort_error", error, 2'b00);
    check("abort_inst", inst_rdata, 32'd63);
    rst_n = 1'b1; no_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reinit_ready", ready, 1'b0);
    mem_init_done = 1'b1;
    @(negedge clk);
    check("reinit_up", ready, 1'b1);
    exp_err = 2'b00; exp_drd = 32'h0; exp_inst = 32'd63;
    run_cmd(3'd1, 32'h120, 32'h0, 32'h0, 4'h0, 0);
    run_cmd(3'd2, 32'h124, 32'h2000, 32'h0, 4'h0, 0);

    check("req_stable", stab_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/agp32_mem_ctrl.md
Name: agp32_mem_ctrl

Overview:
- Memory controller directly downstream of the agp32 pipelined processor. It consumes the processor's command / data_addr / data_wdata / data_wstrb bus and returns ready, inst_rdata, data_rdata, error and mem_start_ready.
- It serialises each command into one or two word transactions on a single-port backing-memory req/ack interface: an optional data access, then always an instruction fetch at PC.

Parameters:
- TIMEOUT, 255: max cycles mem_req may stay unacknowledged before a timeout error (TIMEOUT_EN only).
- RESET_INST, 32'd63: inst_rdata value after reset; it is the processor's bubble encoding.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- command  input  3  0 none, 1 fetch, 2 data read, 3 data write, 4 interrupt fetch.
- PC  input  32  instruction fetch address.
- data_addr  input  32  data byte address.
- data_wdata  input  32  write data.
- data_wstrb  input  4  byte write strobes.
- ready  output  1  controller idle; read data valid.
- inst_rdata  output  32  fetched instruction.
- data_rdata  output  32  data read result.
- error  output  2  0 ok, bit0 misaligned, bit1 timeout; sticky.
- mem_start_ready  output  1  backing memory initialised.
- mem_init_done  input  1  backing memory calibration complete.
- mem_req  output  1  backing request; held until ack.
- mem_we  output  1  write request.
- mem_addr  output  30  word address, byte address [31:2].
- mem_wdata  output  32  write data.
- mem_wstrb  output  4  write strobes.
- mem_ack  input  1  request completed; mem_rdata valid this cycle.
- mem_rdata  input  32  read data.

Behaviour:
- Reset (rst_n=0 at posedge), all outputs:
  - ready=0, mem_start_ready=0, error=0
  - inst_rdata=RESET_INST, data_rdata=0
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0
  - state=S_INIT
- Reset mid-transaction aborts immediately: mem_req drops the next cycle and no ack is waited for.
- S_INIT:
  - Wait for mem_init_done=1.
  - Next cycle: mem_start_ready=1 (held until reset), ready=1, go to S_IDLE.
- S_IDLE (ready=1):
  - command=0: remain.
  - command!=0: latch command, data_addr, data_wdata, data_wstrb and PC; ready=0 next cycle.
  - Commands 2/3 go to S_DATA; commands 1/4 go to S_INST.
  - Command values 5-7 are treated as 1.
  - Commands that arrive while ready=0 are ignored.
- Misalignment check (commands 2 and 3, latched data_addr[1:0]!=0):
  - Sets error[0]; no data transaction; go straight to S_INST.
  - Exception: command 3 is not flagged when exactly one strobe bit is set (byte store).
- S_DATA:
  - mem_req=1, mem_we=(cmd==3), mem_addr=addr[31:2]; on a write, also drive wdata and wstrb.
  - On mem_ack: for a read, capture mem_rdata into data_rdata; deassert mem_req the following cycle; go to S_INST.
- S_INST:
  - mem_req=1, mem_we=0, mem_addr=PC_latched[31:2].
  - On mem_ack: inst_rdata<=mem_rdata, ready=1, go to S_IDLE.
- Request rules:
  - mem_req asserts one cycle after state entry.
  - Address, wdata, wstrb and we are stable while mem_req=1.
  - Ack is honoured only while mem_req=1.
- Command 4: same as 1; data_addr is ignored.
- Latency: accept at cycle 0; with zero-wait ack, ready returns at cycle 3 for a fetch and cycle 5 for a data command.
- Output hold: inst_rdata and data_rdata are held stable until overwritten by a later successful transaction.
- Sticky errors: error bits are cleared only by reset, and later commands are still serviced.
- PC wrap: PC=0xFFFFFFFC gives mem_addr=0x3FFFFFFF; there is no increment inside the block.

Optional Feature:
- Macro TIMEOUT_EN, defined:
  - A counter runs while mem_req=1 and resets to 0 on each new request.
  - If it reaches TIMEOUT without ack: set error[1], drop mem_req, and skip the remaining transaction.
  - Timed-out data read: data_rdata unchanged; continue to S_INST.
  - Timed-out fetch: inst_rdata=RESET_INST; ready=1; go to S_IDLE.
- Undefined: no counter; the controller waits for ack indefinitely; error[1] is tied to 0.

Test Plan:
- Startup: hold mem_init_done=0 for 10 cycles after reset → ready=0, mem_start_ready=0 throughout. Then raise it → both rise 1 cycle later; inst_rdata=63.
- Fetch: command=1, PC=0x100, memory returns 0xDEADBEEF after 2 wait cycles → one request with mem_addr=0x40, mem_we=0; then inst_rdata=0xDEADBEEF, ready=1.
- Data read: command=2, data_addr=0x2000, PC=0x104 → read of word 0x800 then fetch of word 0x41, strictly ordered; data_rdata captured from the first ack.
- Byte write: command=3, data_addr=0x2003, wstrb=4'b1000, wdata=0xAB000000 → mem_we=1, mem_addr=0x800, mem_wstrb=4'b1000, error=0.
- Misaligned: command=2, data_addr=0x2002 → error=2'b01; no data request; fetch still performed; ready returns.
- Timeout (TIMEOUT_EN, TIMEOUT=8): mem_ack never asserted on a fetch → mem_req drops after 8 cycles; error[1]=1; inst_rdata=63; ready=1. Separately, rst_n pulsed mid-S_DATA → mem_req=0 the next cycle and the controller re-enters S_INIT.
